apb_req_master: RTL and testbench

- APB initiator: converts a single-outstanding request/response handshake into APB3 transfers (SETUP/ACCESS, PREADY wait states, PSLVERR).
- Drives APB responders such as the accelerator register block from the core-side test/control logic.
- Used both as the RTL bus driver and as the bench's APB driver.
- Adds a configurable PREADY timeout so a hung responder cannot stall the requester.

---
 rtl/apb_req_master_if.sv | 26 ++
 rtl/apb_req_master.sv | 157 +++++++++++++++
 tb/tb_apb_req_master.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_req_master_if.sv
// APB3 bus bundle between one initiator and one responder.
//   PADDR/PWDATA/PWRITE/PSEL/PENABLE : driven by the initiator (master modport)
//   PRDATA/PREADY/PSLVERR            : driven by the responder (slave modport)
`timescale 1ns/1ps
interface apb_req_master_if #(
  parameter int ADDR_WIDTH = 12
) ();
  logic [ADDR_WIDTH-1:0] PADDR;
  logic [31:0]           PWDATA;
  logic                  PWRITE;
  logic                  PSEL;
  logic                  PENABLE;
  logic [31:0]           PRDATA;
  logic                  PREADY;
  logic                  PSLVERR;

  modport master (
    output PADDR, PWDATA, PWRITE, PSEL, PENABLE,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PADDR, PWDATA, PWRITE, PSEL, PENABLE,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_req_master.sv
// APB3 initiator: turns a single-outstanding request/response handshake into
// APB SETUP/ACCESS transfers, with PREADY wait states, PSLVERR reporting and
// an optional PREADY timeout that aborts a transfer to a hung responder.
//   HCLK, HRESETn      : clock (rising edge), asynchronous active-low reset
//   req_*              : request channel (valid/ready, addr, wdata, write)
//   rsp_*              : response channel (valid/ready, rdata, err, timeout)
//   apb (master)       : APB3 bus towards the responder
`timescale 1ns/1ps
module apb_req_master #(
  parameter int APB_ADDR_WIDTH = 12,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                      HCLK,
  input  logic                      HRESETn,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [APB_ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]               req_wdata,
  input  logic                      req_write,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [31:0]               rsp_rdata,
  output logic                      rsp_err,
  output logic                      rsp_timeout,
  apb_req_master_if.master          apb
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  localparam bit          TO_EN   = (TIMEOUT_CYCLES != 0);
  // Counter value seen in the last permitted wait cycle; only meaningful when TO_EN.
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t                    state_q, state_d;
  logic [APB_ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [31:0]               pwdata_q, pwdata_d;
  logic                      pwrite_q, pwrite_d;
  logic                      psel_q, psel_d;
  logic                      penable_q, penable_d;
  logic                      rsp_valid_q, rsp_valid_d;
  logic [31:0]               rsp_rdata_q, rsp_rdata_d;
  logic                      rsp_err_q, rsp_err_d;
  logic                      rsp_timeout_q, rsp_timeout_d;
  logic [15:0]               cnt_q, cnt_d;

  // NOTE: every output of this block is given a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d       = state_q;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
    pwrite_d      = pwrite_q;
    psel_d        = psel_q;
    penable_d     = penable_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;
    cnt_d         = cnt_q;

    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          paddr_d  = req_addr;
          pwdata_d = req_wdata;
          pwrite_d = req_write;
          psel_d   = 1'b1;
          cnt_d    = '0;
          state_d  = SETUP;
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        state_d   = ACCESS;
      end
      ACCESS: begin
        // PREADY is checked first so it wins over a simultaneous timeout.
        if (apb.PREADY) begin
          rsp_rdata_d   = pwrite_q ? 32'h0 : apb.PRDATA;
          rsp_err_d     = apb.PSLVERR;
          rsp_timeout_d = 1'b0;
          rsp_valid_d   = 1'b1;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          state_d       = RESP;
        end else begin
          cnt_d = cnt_q + 16'd1;
          if (TO_EN && cnt_q == TO_LAST) begin
            rsp_rdata_d   = 32'h0;
            rsp_err_d     = 1'b1;
            rsp_timeout_d = 1'b1;
            rsp_valid_d   = 1'b1;
            psel_d        = 1'b0;
            penable_d     = 1'b0;
            state_d       = RESP;
          end
        end
      end
      RESP: begin
        // rsp_rdata deliberately keeps its value after the handshake.
        if (rsp_ready) begin
          rsp_valid_d   = 1'b0;
          rsp_err_d     = 1'b0;
          rsp_timeout_d = 1'b0;
          state_d       = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of the others.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      paddr_q       <= '0;
      pwdata_q      <= '0;
      pwrite_q      <= 1'b0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
      cnt_q         <= '0;
    end else begin
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      pwrite_q      <= pwrite_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
      cnt_q         <= cnt_d;
    end
  end

  assign req_ready   = (state_q == IDLE);
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;

  assign apb.PADDR   = paddr_q;
  assign apb.PWDATA  = pwdata_q;
  assign apb.PWRITE  = pwrite_q;
  assign apb.PSEL    = psel_q;
  assign apb.PENABLE = penable_q;

endmodule

// File: tb/tb_apb_req_master.sv
// Directed bench for apb_req_master (TIMEOUT_CYCLES = 8). Inputs change and
// outputs are sampled on the falling clock edge; "cycle N" is the cycle in
// which a request is presented and accepted at its closing rising edge.
`timescale 1ns/1ps
module tb_apb_req_master;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        req_valid;
  logic        req_ready;
  logic [11:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_write;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;

  int n_cmp = 0;
  int n_err = 0;

  apb_req_master_if #(.ADDR_WIDTH(12)) apb ();

  apb_req_master #(.APB_ADDR_WIDTH(12), .TIMEOUT_CYCLES(8)) dut (
    .HCLK        (HCLK),
    .HRESETn     (HRESETn),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .req_write   (req_write),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .rsp_timeout (rsp_timeout),
    .apb         (apb)
  );

  always #5 HCLK = ~HCLK;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Present a request for the current cycle (stimulus only).
  task automatic start_req(input logic [11:0] a, input logic [31:0] d, input logic w);
    req_valid = 1'b1;
    req_addr  = a;
    req_wdata = d;
    req_write = w;
  endtask

  task automatic test_reset();
    HRESETn = 1'b0; req_valid = 1'b0; req_addr = '0; req_wdata = '0; req_write = 1'b0;
    rsp_ready = 1'b1; apb.PRDATA = '0; apb.PREADY = 1'b0; apb.PSLVERR = 1'b0;
    @(negedge HCLK); @(negedge HCLK);
    n_cmp++; if ({req_ready, apb.PSEL, apb.PENABLE, apb.PWRITE} !== 4'b1000) begin
      n_err++; $display("FAIL reset_ctrl: got %b want 1000", {req_ready, apb.PSEL, apb.PENABLE, apb.PWRITE}); end
    n_cmp++; if ({apb.PADDR, apb.PWDATA} !== 44'h0) begin
      n_err++; $display("FAIL reset_addr_data: got %h want 0", {apb.PADDR, apb.PWDATA}); end
    n_cmp++; if ({rsp_valid, rsp_err, rsp_timeout, rsp_rdata} !== 35'h0) begin
      n_err++; $display("FAIL reset_rsp: got %h want 0", {rsp_valid, rsp_err, rsp_timeout, rsp_rdata}); end
    HRESETn = 1'b1;
    @(negedge HCLK);
  endtask

  task automatic test_write();
    apb.PREADY = 1'b1; apb.PSLVERR = 1'b0; rsp_ready = 1'b1;
    start_req(12'h010, 32'hDEAD_BEEF, 1'b1);             // N
    n_cmp++; if (req_ready !== 1'b1) begin
      n_err++; $display("FAIL wr_ready_N: got %b want 1", req_ready); end
    @(negedge HCLK); req_valid = 1'b0;                   // N+1 SETUP
    n_cmp++; if ({apb.PSEL, apb.PENABLE, req_ready} !== 3'b100) begin
      n_err++; $display("FAIL wr_setup: got %b want 100", {apb.PSEL, apb.PENABLE, req_ready}); end
    @(negedge HCLK);                                     // N+2 ACCESS
    n_cmp++; if ({apb.PSEL, apb.PENABLE, apb.PWRITE, rsp_valid} !== 4'b1110) begin
      n_err++; $display("FAIL wr_access: got %b want 1110", {apb.PSEL, apb.PENABLE, apb.PWRITE, rsp_valid}); end
    n_cmp++; if (apb.PADDR !== 12'h010 || apb.PWDATA !== 32'hDEAD_BEEF) begin
      n_err++; $display("FAIL wr_addr_data: got %h/%h want 010/deadbeef", apb.PADDR, apb.PWDATA); end
    @(negedge HCLK);                                     // N+3 RESP
    n_cmp++; if ({rsp_valid, rsp_err, rsp_timeout, apb.PSEL, apb.PENABLE} !== 5'b10000) begin
      n_err++; $display("FAIL wr_rsp: got %b want 10000", {rsp_valid, rsp_err, rsp_timeout, apb.PSEL, apb.PENABLE}); end
    n_cmp++; if (rsp_rdata !== 32'h0) begin
      n_err++; $display("FAIL wr_rdata: got %h want 0", rsp_rdata); end
    @(negedge HCLK);                                     // N+4 IDLE
    n_cmp++; if ({rsp_valid, req_ready} !== 2'b01) begin
      n_err++; $display("FAIL wr_idle: got %b want 01", {rsp_valid, req_ready}); end
  endtask

  task automatic test_read_wait();
    apb.PREADY = 1'b0; apb.PSLVERR = 1'b1; apb.PRDATA = 32'hFFFF_0000; rsp_ready = 1'b1;
    start_req(12'h004, 32'h0, 1'b0);                     // N
    @(negedge HCLK); req_valid = 1'b0;                   // N+1
    for (int k = 1; k <= 4; k++) begin                   // ACCESS N+2..N+5
      @(negedge HCLK);
      n_cmp++; if ({apb.PSEL, apb.PENABLE, apb.PWRITE, rsp_valid} !== 4'b1100 || apb.PADDR !== 12'h004) begin
        n_err++; $display("FAIL rd_wait_access%0d: got %b/%h want 1100/004", k,
                          {apb.PSEL, apb.PENABLE, apb.PWRITE, rsp_valid}, apb.PADDR); end
      if (k == 4) begin apb.PREADY = 1'b1; apb.PSLVERR = 1'b0; apb.PRDATA = 32'h1234_5678; end
    end
    @(negedge HCLK);                                     // N+6
    apb.PREADY = 1'b0; apb.PRDATA = 32'h0;
    n_cmp++; if ({rsp_valid, rsp_err, rsp_timeout, apb.PSEL} !== 4'b1000) begin
      n_err++; $display("FAIL rd_wait_rsp: got %b want 1000", {rsp_valid, rsp_err, rsp_timeout, apb.PSEL}); end
    n_cmp++; if (rsp_rdata !== 32'h1234_5678) begin
      n_err++; $display("FAIL rd_wait_rdata: got %h want 12345678", rsp_rdata); end
    @(negedge HCLK);
  endtask

  task automatic test_timeout();
    apb.PREADY = 1'b0; apb.PSLVERR = 1'b0; apb.PRDATA = 32'hFFFF_FFFF; rsp_ready = 1'b1;
    start_req(12'h030, 32'h0, 1'b0);
    @(negedge HCLK); req_valid = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge HCLK);
      n_cmp++; if ({apb.PSEL, apb.PENABLE, rsp_valid} !== 3'b110) begin
        n_err++; $display("FAIL to_wait%0d: got %b want 110", k, {apb.PSEL, apb.PENABLE, rsp_valid}); end
    end
    @(negedge HCLK);
    n_cmp++; if ({rsp_valid, rsp_err, rsp_timeout, apb.PSEL, apb.PENABLE} !== 5'b11100) begin
      n_err++; $display("FAIL to_abort: got %b want 11100", {rsp_valid, rsp_err, rsp_timeout, apb.PSEL, apb.PENABLE}); end
    n_cmp++; if (rsp_rdata !== 32'h0) begin
      n_err++; $display("FAIL to_rdata: got %h want 0", rsp_rdata); end
    @(negedge HCLK);
    n_cmp++; if ({rsp_valid, rsp_err, rsp_timeout, req_ready} !== 4'b0001) begin
      n_err++; $display("FAIL to_clear: got %b want 0001", {rsp_valid, rsp_err, rsp_timeout, req_ready}); end
    // Same again, but PREADY arrives in the 8th ACCESS cycle.
    start_req(12'h034, 32'h0, 1'b0);
    @(negedge HCLK); req_valid = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge HCLK);
      if (k == 8) begin apb.PREADY = 1'b1; apb.PRDATA = 32'h0BAD_F00D; end
    end
    @(negedge HCLK);
    apb.PREADY = 1'b0;
    n_cmp++; if ({rsp_valid, rsp_err, rsp_timeout} !== 3'b100 || rsp_rdata !== 32'h0BAD_F00D) begin
      n_err++; $display("FAIL to_edge_ready: got %b/%h want 100/0badf00d", {rsp_valid, rsp_err, rsp_timeout}, rsp_rdata); end
    @(negedge HCLK);
  endtask

  task automatic test_slverr();
    apb.PREADY = 1'b1; apb.PSLVERR = 1'b1; apb.PRDATA = 32'hA5A5_0F0F; rsp_ready = 1'b1;
    start_req(12'h020, 32'h0, 1'b0);
    @(negedge HCLK); req_valid = 1'b0;
    @(negedge HCLK);
    @(negedge HCLK);                                     // N+3
    apb.PSLVERR = 1'b0;
    n_cmp++; if ({rsp_valid, rsp_err, rsp_timeout} !== 3'b110 || rsp_rdata !== 32'hA5A5_0F0F) begin
      n_err++; $display("FAIL slv_rsp: got %b/%h want 110/a5a50f0f", {rsp_valid, rsp_err, rsp_timeout}, rsp_rdata); end
    @(negedge HCLK);
    n_cmp++; if ({req_ready, rsp_err} !== 2'b10) begin
      n_err++; $display("FAIL slv_idle: got %b want 10", {req_ready, rsp_err}); end
    start_req(12'h024, 32'hCAFE_F00D, 1'b1);
    @(negedge HCLK); req_valid = 1'b0;
    n_cmp++; if ({apb.PSEL, apb.PENABLE, apb.PWRITE} !== 3'b101 || apb.PADDR !== 12'h024) begin
      n_err++; $display("FAIL slv_next_setup: got %b/%h want 101/024", {apb.PSEL, apb.PENABLE, apb.PWRITE}, apb.PADDR); end
    @(negedge HCLK);
    @(negedge HCLK);
    n_cmp++; if ({rsp_valid, rsp_err} !== 2'b10 || rsp_rdata !== 32'h0) begin
      n_err++; $display("FAIL slv_next_rsp: got %b/%h want 10/0", {rsp_valid, rsp_err}, rsp_rdata); end
    @(negedge HCLK);
  endtask

  task automatic test_rsp_backpressure();
    apb.PREADY = 1'b1; apb.PSLVERR = 1'b0; apb.PRDATA = 32'h0000_55AA; rsp_ready = 1'b0;
    start_req(12'h050, 32'h0, 1'b0);
    @(negedge HCLK); req_valid = 1'b0;
    @(negedge HCLK);
    @(negedge HCLK);                                     // N+3 response up
    apb.PRDATA = 32'hFFFF_FFFF;
    start_req(12'h060, 32'h1111_2222, 1'b1);             // must wait for IDLE
    for (int k = 0; k < 5; k++) begin                    // N+3..N+7
      if (k > 0) @(negedge HCLK);
      n_cmp++; if ({rsp_valid, rsp_err, rsp_timeout, req_ready, apb.PSEL} !== 5'b10000 || rsp_rdata !== 32'h0000_55AA) begin
        n_err++; $display("FAIL bp_hold%0d: got %b/%h want 10000/000055aa", k,
                          {rsp_valid, rsp_err, rsp_timeout, req_ready, apb.PSEL}, rsp_rdata); end
    end
    rsp_ready = 1'b1;
    @(negedge HCLK);                                     // N+8 IDLE
    n_cmp++; if ({rsp_valid, req_ready, apb.PSEL} !== 3'b010 || rsp_rdata !== 32'h0000_55AA) begin
      n_err++; $display("FAIL bp_release: got %b/%h want 010/000055aa", {rsp_valid, req_ready, apb.PSEL}, rsp_rdata); end
    @(negedge HCLK); req_valid = 1'b0;                   // N+9 SETUP of queued request
    n_cmp++; if ({apb.PSEL, apb.PWRITE} !== 2'b11 || apb.PADDR !== 12'h060) begin
      n_err++; $display("FAIL bp_next: got %b/%h want 11/060", {apb.PSEL, apb.PWRITE}, apb.PADDR); end
    repeat (3) @(negedge HCLK);
  endtask

  task automatic test_back_to_back();
    logic [10:0] hist;
    int          n_rsp;
    hist = '0; n_rsp = 0;
    apb.PREADY = 1'b1; apb.PSLVERR = 1'b0; rsp_ready = 1'b1;
    start_req(12'h070, 32'h0000_0001, 1'b1);
    for (int i = 0; i <= 10; i++) begin
      if (i > 0) @(negedge HCLK);
      hist[i] = apb.PSEL;
      if (rsp_valid) n_rsp++;
    end
    req_valid = 1'b0;
    n_cmp++; if (hist !== 11'b110_0110_0110) begin
      n_err++; $display("FAIL b2b_psel_pattern: got %b want 11001100110", hist); end
    n_cmp++; if (n_rsp != 2) begin
      n_err++; $display("FAIL b2b_rsp_count: got %0d want 2", n_rsp); end
    repeat (2) @(negedge HCLK);
    n_cmp++; if ({req_ready, rsp_valid, apb.PSEL} !== 3'b100) begin
      n_err++; $display("FAIL b2b_drain: got %b want 100", {req_ready, rsp_valid, apb.PSEL}); end
  endtask

  task automatic test_reset_mid();
    int spurious;
    spurious = 0;
    apb.PREADY = 1'b0; rsp_ready = 1'b1;
    start_req(12'h040, 32'h0, 1'b0);
    @(negedge HCLK); req_valid = 1'b0;
    @(negedge HCLK);                                     // ACCESS
    n_cmp++; if ({apb.PSEL, apb.PENABLE} !== 2'b11) begin
      n_err++; $display("FAIL rst_pre: got %b want 11", {apb.PSEL, apb.PENABLE}); end
    #2 HRESETn = 1'b0;
    #1;
    n_cmp++; if ({apb.PSEL, apb.PENABLE, rsp_valid, req_ready} !== 4'b0001) begin
      n_err++; $display("FAIL rst_async: got %b want 0001", {apb.PSEL, apb.PENABLE, rsp_valid, req_ready}); end
    @(negedge HCLK); @(negedge HCLK);
    HRESETn = 1'b1; apb.PREADY = 1'b1;
    repeat (6) begin
      @(negedge HCLK);
      if (rsp_valid || apb.PSEL || !req_ready) spurious++;
    end
    n_cmp++; if (spurious != 0) begin
      n_err++; $display("FAIL rst_no_spurious: got %0d bad cycles want 0", spurious); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_wait();
    test_timeout();
    test_slverr();
    test_rsp_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
